// File: rtl/constants.svh
// Widths shared by the UART transmit path.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH
`define MESSAGE_SIZE 8
`endif

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ
// requesters, with busy handshake, busy timeout and an inter-frame gap.
`include "constants.svh"

module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = 2604,
    parameter int BUSY_TIMEOUT = 8192
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*`MESSAGE_SIZE-1:0] req_data,
    input  logic                             tx_busy,
    output logic [NUM_REQ-1:0]               grant,
    output logic [`MESSAGE_SIZE-1:0]         tx_data,
    output logic                             tx_start,
    output logic [$clog2(NUM_REQ)-1:0]       tx_id,
    output logic                             err_timeout
);
    localparam int MS   = `MESSAGE_SIZE;
    localparam int IDW  = $clog2(NUM_REQ);
    localparam int TMAX = (GAP_CYCLES > BUSY_TIMEOUT) ?
                          GAP_CYCLES : BUSY_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_e;

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [MS-1:0]      tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [IDW-1:0]     tx_id_q, tx_id_d;
    logic               err_timeout_q, err_timeout_d;

    logic [NUM_REQ-1:0] above_last;
    logic [NUM_REQ-1:0] pool;
    logic [IDW-1:0]     winner;
    logic [MS-1:0]      winner_data;

    // Requests above the last winner go first; if none, wrap to index 0.
    always_comb begin
        above_last = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            above_last[i] = (IDW'(i) > last_grant_q);
        end
        pool = ((req & above_last) != '0) ? (req & above_last) : req;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pool[i]) winner = IDW'(i);
        end
        winner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                winner_data = req_data[i*MS +: MS];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        last_grant_d  = last_grant_q;
        grant_d       = '0;
        tx_start_d    = 1'b0;
        err_timeout_d = 1'b0;
        tx_data_d     = tx_data_q;
        tx_id_d       = tx_id_q;
        unique case (state_q)
            IDLE: begin
                if (req != '0) begin
                    grant_d      = NUM_REQ'(1) << winner;
                    tx_data_d    = winner_data;
                    tx_id_d      = winner;
                    last_grant_d = winner;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                tx_start_d = 1'b1;
                state_d    = START;
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == BUSY_LAST) begin
                    err_timeout_d = 1'b1;
                    timer_d       = '0;
                    state_d       = GAP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    timer_d = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            last_grant_q  <= IDW'(NUM_REQ - 1);
            grant_q       <= '0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            tx_id_q       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            tx_id_q       <= tx_id_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign tx_id       = tx_id_q;
    assign err_timeout = err_timeout_q;

    a_grant_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot0(grant_q));

    a_start_single: assert property (
        @(posedge clk) disable iff (rst) tx_start_q |=> !tx_start_q);

    // Payload may only move on a grant or as a result of reset.
    a_data_stable: assert property (
        @(posedge clk) disable iff (rst)
        $changed(tx_data_q) |-> (grant_q != '0 || $past(rst)));

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-timeline model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
`ifndef MESSAGE_SIZE
`define MESSAGE_SIZE 8
`endif

module tb_uart_tx_scheduler;
    localparam int NR  = 4;
    localparam int G   = 5;
    localparam int BT  = 20;
    localparam int MS  = `MESSAGE_SIZE;
    localparam int IDW = $clog2(NR);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR*MS-1:0] req_data = '0;
    logic             tx_busy = 1'b0;
    logic [NR-1:0]    grant;
    logic [MS-1:0]    tx_data;
    logic             tx_start;
    logic [IDW-1:0]   tx_id;
    logic             err_timeout;

    uart_tx_scheduler #(
        .NUM_REQ(NR),
        .GAP_CYCLES(G),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .tx_busy(tx_busy),
        .grant(grant),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_id(tx_id),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Model state: cycle n is the interval after rising edge n.
    int            cyc = 0;
    bit            mvalid = 1'b0;
    int            last = NR - 1;
    int            avail = 0;
    int            g_cyc = -100;
    int            g_w = 0;
    int            e_cyc = -100;
    logic [MS-1:0] exp_data = '0;
    int            exp_id = 0;
    int            b_from = 0;
    int            b_to = 0;
    int            mode = 0;
    int            fix_d = 0;
    int            fix_l = 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h",
                      name, cyc, act, exp);
    endtask

    function automatic int rr_pick(input logic [NR-1:0] r, input int l);
        for (int k = 1; k <= NR; k++) begin
            if (r[(l + k) % NR]) return (l + k) % NR;
        end
        return -1;
    endfunction

    // Frame timeline: sample edge s -> grant cycle s, start s+1,
    // busy watched from s+2; gap of G cycles, then one idle cycle.
    initial begin
        int w, d, l;
        bit tmo;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mvalid   = 1'b1;
                last     = NR - 1;
                avail    = cyc + 1;
                g_cyc    = -100;
                e_cyc    = -100;
                exp_data = '0;
                exp_id   = 0;
                b_from   = 0;
                b_to     = 0;
            end else if (mvalid && cyc >= avail && req != '0) begin
                w        = rr_pick(req, last);
                last     = w;
                g_cyc    = cyc;
                g_w      = w;
                exp_data = req_data[w*MS +: MS];
                exp_id   = w;
                tmo      = 1'b0;
                d        = fix_d;
                l        = fix_l;
                if (mode == 2) tmo = 1'b1;
                if (mode == 0) begin
                    tmo = ($urandom_range(0, 7) == 0);
                    d = ($urandom_range(0, 3) == 0) ?
                        BT - 1 : $urandom_range(0, 5);
                    l = $urandom_range(1, 12);
                end
                if (tmo) begin
                    e_cyc  = cyc + 2 + BT;
                    b_from = 0;
                    b_to   = 0;
                    avail  = cyc + 2 + BT + G + 1;
                end else begin
                    e_cyc  = -100;
                    b_from = cyc + 2 + d;
                    b_to   = b_from + l;
                    avail  = cyc + 3 + d + l + G + 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        tx_busy = (cyc >= b_from) && (cyc < b_to);
    end

    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            logic [NR-1:0] eg;
            eg = (cyc == g_cyc) ? (NR'(1) << g_w) : '0;
            chk("grant", grant, eg);
            chk("tx_start", tx_start, cyc == g_cyc + 1);
            chk("err_timeout", err_timeout, cyc == e_cyc);
            chk("tx_data", tx_data, exp_data);
            chk("tx_id", tx_id, exp_id);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req = '0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output int idx,
                              output int at);
        idx = -1;
        at  = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (grant != '0) begin
                for (int i = 0; i < NR; i++) if (grant[i]) idx = i;
                at = cyc;
                return;
            end
        end
        checks++;
        $display("FAIL grant_wait: none within %0d cycles at %0d",
                 budget, cyc);
    endtask

    initial begin
        int idx, g1, g2, t0, s, e, prev;
        int order [5] = '{0, 1, 2, 3, 0};

        // Single frame with a 100-cycle transmitter busy window.
        mode  = 1;
        fix_d = 0;
        fix_l = 100;
        repeat (3) step();
        @(negedge clk);
        chk("reset_outputs",
            {grant, tx_start, err_timeout, tx_data, tx_id}, 0);
        step();
        rst = 1'b0;
        req = 4'b0001;
        req_data[0 +: MS] = 8'hA5;
        t0 = cyc;
        wait_grant(20, idx, g1);
        chk("A_grant", grant, 4'b0001);
        chk("A_data", tx_data, 8'hA5);
        chk("A_id", tx_id, 0);
        chk("A_latency", g1 - t0, 1);
        step();
        req = '0;
        @(negedge clk);
        chk("A_start", tx_start, 1);
        step();
        req = 4'b0010;
        req_data[MS +: MS] = 8'h3C;
        wait_grant(200, idx, g2);
        chk("A_next_id", idx, 1);
        chk("A_spacing", g2 - g1, 104 + G);
        chk("A_data2", tx_data, 8'h3C);

        // All four requesting: strict rotation from requester 0.
        do_reset(2);
        mode  = 1;
        fix_d = 1;
        fix_l = 3;
        for (int i = 0; i < NR; i++) req_data[i*MS +: MS] = MS'(8'h10 + i);
        req  = '1;
        prev = -1;
        for (int n = 0; n < 5; n++) begin
            wait_grant(60, idx, g1);
            chk("B_order", idx, order[n]);
            chk("B_data", tx_data, 8'h10 + order[n]);
            if (n > 0) chk("B_spacing", g1 - prev, 4 + 1 + 3 + G);
            prev = g1;
        end

        // Requester 0 never lets go; requester 2 must still get in.
        do_reset(2);
        mode  = 1;
        fix_d = 0;
        fix_l = 10;
        req = 4'b0001;
        wait_grant(20, idx, g1);
        chk("C_first", idx, 0);
        step();
        req[2] = 1'b1;
        req_data[2*MS +: MS] = 8'h77;
        wait_grant(100, idx, g1);
        chk("C_second", idx, 2);
        chk("C_data", tx_data, 8'h77);
        step();
        req[2] = 1'b0;
        wait_grant(100, idx, g1);
        chk("C_third", idx, 0);

        // Transmitter never answers.
        do_reset(2);
        mode = 2;
        req  = 4'b0100;
        wait_grant(20, idx, g1);
        chk("D_id", idx, 2);
        step();
        req = '0;
        @(negedge clk);
        chk("D_start", tx_start, 1);
        s = cyc;
        e = -1;
        for (int k = 0; k < BT + 10; k++) begin
            @(negedge clk);
            if (err_timeout) begin
                e = cyc;
                break;
            end
        end
        if (e < 0) begin
            checks++;
            $display("FAIL D_err_wait: no err_timeout by cycle %0d", cyc);
        end else begin
            chk("D_err_delay", e - s, BT + 1);
            @(negedge clk);
            chk("D_err_pulse", err_timeout, 0);
        end
        step();
        req = 4'b0001;
        wait_grant(60, idx, g2);
        chk("D_next_id", idx, 0);
        chk("D_spacing", g2 - g1, BT + G + 3);

        // Reset while the transmitter is busy and requester 1 waits.
        do_reset(2);
        mode  = 1;
        fix_d = 0;
        fix_l = 40;
        req = 4'b0001;
        wait_grant(20, idx, g1);
        step();
        req = 4'b0010;
        req_data[MS +: MS] = 8'h5A;
        repeat (10) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("E_rst_outputs",
            {grant, tx_start, err_timeout, tx_data, tx_id}, 0);
        step();
        rst = 1'b0;
        t0  = cyc;
        wait_grant(10, idx, g2);
        chk("E_grant", grant, 4'b0010);
        chk("E_latency", g2 - t0, 1);
        chk("E_data", tx_data, 8'h5A);

        // Random traffic, busy profiles and occasional resets.
        do_reset(2);
        mode = 0;
        for (int n = 0; n < 4000; n++) begin
            step();
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < NR; i++) begin
                if (req[i] && g_cyc == cyc - 1 && g_w == i) begin
                    req[i] = 1'b0;
                end else if (req[i] && $urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*MS +: MS] = MS'($urandom);
                end
            end
        end
        rst = 1'b0;
        req = '0;
        repeat (5) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
